load_issue_pipe: RTL and testbench

LOAD_ISSUE_PIPE -- requirements
Module: load_issue_pipe

---
 rtl/load_issue_pipe.sv | 156 +++++++++++++++
 tb/tb_load_issue_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_issue_pipe.sv
// rtl/load_issue_pipe.sv - single-issue load pipeline: oldest-ready select, dependence check, L1 access, writeback
module load_issue_pipe #(
    parameter int LDQ_SIZE = 8,
    parameter int STQ_SIZE = 8,
    parameter int XLEN     = 32,
    parameter int TAG_W    = 5,
    localparam int LDQ_IDX_W = $clog2(LDQ_SIZE),
    localparam int STQ_IDX_W = $clog2(STQ_SIZE)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [LDQ_SIZE-1:0]       ldq_ready,
    input  logic [LDQ_IDX_W-1:0]      ldq_head,
    input  logic [LDQ_SIZE*XLEN-1:0]  ldq_address,
    input  logic [LDQ_SIZE*TAG_W-1:0] ldq_rob_tag,
    output logic [LDQ_IDX_W-1:0]      sel_index,
    input  logic                      kill_mem_req,
    input  logic                      forward,
    input  logic [STQ_IDX_W-1:0]      stq_forward_index,
    input  logic [STQ_SIZE*XLEN-1:0]  stq_data,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [XLEN-1:0]           mem_req_addr,
    input  logic                      mem_resp_valid,
    input  logic [XLEN-1:0]           mem_resp_data,
    output logic                      ldq_sleep_valid,
    output logic [LDQ_IDX_W-1:0]      ldq_sleep_index,
    output logic                      ldq_done_valid,
    output logic [LDQ_IDX_W-1:0]      ldq_done_index,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [XLEN-1:0]           wb_data,
    output logic [TAG_W-1:0]          wb_rob_tag
);

    typedef enum logic [2:0] {IDLE, SEARCH, MEM_REQ, MEM_WAIT, WB, DRAIN} state_t;

    state_t               state;
    logic [LDQ_IDX_W-1:0] ld_idx;
    logic [XLEN-1:0]      ld_addr;
    logic [TAG_W-1:0]     ld_tag;
    logic [XLEN-1:0]      result;

    logic [XLEN-1:0]  ldq_addr_arr [LDQ_SIZE];
    logic [TAG_W-1:0] ldq_tag_arr  [LDQ_SIZE];
    logic [XLEN-1:0]  stq_data_arr [STQ_SIZE];

    for (genvar g = 0; g < LDQ_SIZE; g++) begin : g_ldq_unpack
        assign ldq_addr_arr[g] = ldq_address[g*XLEN +: XLEN];
        assign ldq_tag_arr[g]  = ldq_rob_tag[g*TAG_W +: TAG_W];
    end

    for (genvar g = 0; g < STQ_SIZE; g++) begin : g_stq_unpack
        assign stq_data_arr[g] = stq_data[g*XLEN +: XLEN];
    end

    // Oldest ready load: first set bit walking circularly upward from the head.
    logic                 pick_valid;
    logic [LDQ_IDX_W-1:0] pick_idx;

    always_comb begin
        int slot;
        slot       = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < LDQ_SIZE; k++) begin
            slot = int'(ldq_head) + k;
            if (slot >= LDQ_SIZE) begin
                slot = slot - LDQ_SIZE;
            end
            if (!pick_valid && ldq_ready[LDQ_IDX_W'(slot)]) begin
                pick_valid = 1'b1;
                pick_idx   = LDQ_IDX_W'(slot);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ld_idx  <= '0;
            ld_addr <= '0;
            ld_tag  <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid && !flush) begin
                        ld_idx  <= pick_idx;
                        ld_addr <= ldq_addr_arr[pick_idx];
                        ld_tag  <= ldq_tag_arr[pick_idx];
                        state   <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (!kill_mem_req) begin
                        state <= MEM_REQ;
                    end else if (forward) begin
                        result <= stq_data_arr[stq_forward_index];
                        state  <= WB;
                    end else begin
                        state <= IDLE;
                    end
                end
                MEM_REQ: begin
                    // An accepted request still owes us a response, so a flush here must drain it.
                    if (mem_req_ready) begin
                        state <= flush ? DRAIN : MEM_WAIT;
                    end else if (flush) begin
                        state <= IDLE;
                    end
                end
                MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            result <= mem_resp_data;
                            state  <= WB;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                WB: begin
                    if (flush || wb_ready) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sel_index       = (state == SEARCH) ? ld_idx : '0;
    assign ldq_sleep_valid = (state == SEARCH) && kill_mem_req && !forward && !flush;
    assign ldq_sleep_index = ldq_sleep_valid ? ld_idx : '0;

    assign mem_req_valid = (state == MEM_REQ);
    assign mem_req_addr  = mem_req_valid ? ld_addr : '0;

    assign wb_valid       = (state == WB);
    assign wb_data        = wb_valid ? result : '0;
    assign wb_rob_tag     = wb_valid ? ld_tag : '0;
    assign ldq_done_valid = wb_valid && wb_ready && !flush;
    assign ldq_done_index = ldq_done_valid ? ld_idx : '0;

endmodule

// File: tb/tb_load_issue_pipe.sv
// tb/tb_load_issue_pipe.sv - directed bench with a flag-based reference model for load_issue_pipe
module tb_load_issue_pipe;

    localparam int N  = 8;
    localparam int S  = 8;
    localparam int XL = 32;
    localparam int TW = 5;

    logic            clk;
    logic            reset;
    logic            flush;
    logic [N-1:0]    ldq_ready;
    logic [2:0]      ldq_head;
    logic [N*XL-1:0] ldq_address;
    logic [N*TW-1:0] ldq_rob_tag;
    logic [2:0]      sel_index;
    logic            kill_mem_req;
    logic            forward;
    logic [2:0]      stq_forward_index;
    logic [S*XL-1:0] stq_data;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XL-1:0]   mem_req_addr;
    logic            mem_resp_valid;
    logic [XL-1:0]   mem_resp_data;
    logic            ldq_sleep_valid;
    logic [2:0]      ldq_sleep_index;
    logic            ldq_done_valid;
    logic [2:0]      ldq_done_index;
    logic            wb_valid;
    logic            wb_ready;
    logic [XL-1:0]   wb_data;
    logic [TW-1:0]   wb_rob_tag;

    int checks = 0;
    int errors = 0;

    load_issue_pipe #(.LDQ_SIZE(N), .STQ_SIZE(S), .XLEN(XL), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ldq_ready(ldq_ready), .ldq_head(ldq_head),
        .ldq_address(ldq_address), .ldq_rob_tag(ldq_rob_tag),
        .sel_index(sel_index), .kill_mem_req(kill_mem_req), .forward(forward),
        .stq_forward_index(stq_forward_index), .stq_data(stq_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .ldq_sleep_valid(ldq_sleep_valid), .ldq_sleep_index(ldq_sleep_index),
        .ldq_done_valid(ldq_done_valid), .ldq_done_index(ldq_done_index),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rob_tag(wb_rob_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a load is described by progress flags, not by a state register.
    bit          m_load;
    bit          m_checked;
    bit          m_issued;
    bit          m_has_res;
    bit          m_orphan;
    int          m_idx;
    logic [31:0] m_addr;
    logic [31:0] m_res;
    logic [4:0]  m_tag;

    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ldq_head) + k) % N;
            if (ldq_ready[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step();
        int p;
        if (reset) begin
            m_load = 0; m_checked = 0; m_issued = 0; m_has_res = 0; m_orphan = 0;
            m_idx = 0; m_addr = 0; m_res = 0; m_tag = 0;
            return;
        end
        p = model_pick();
        if (m_orphan) begin
            if (mem_resp_valid) m_orphan = 0;
        end else if (!m_load) begin
            if (!flush && p >= 0) begin
                m_load = 1; m_checked = 0; m_issued = 0; m_has_res = 0;
                m_idx  = p;
                m_addr = ldq_address[p*XL +: XL];
                m_tag  = ldq_rob_tag[p*TW +: TW];
            end
        end else if (!m_checked) begin
            if (flush) m_load = 0;
            else if (!kill_mem_req) m_checked = 1;
            else if (forward) begin
                m_checked = 1; m_has_res = 1;
                m_res = stq_data[int'(stq_forward_index)*XL +: XL];
            end else m_load = 0;
        end else if (m_has_res) begin
            if (flush || wb_ready) m_load = 0;
        end else if (!m_issued) begin
            if (mem_req_ready) begin
                if (flush) begin m_load = 0; m_orphan = 1; end
                else m_issued = 1;
            end else if (flush) m_load = 0;
        end else begin
            if (mem_resp_valid) begin
                if (flush) m_load = 0;
                else begin m_has_res = 1; m_res = mem_resp_data; end
            end else if (flush) begin
                m_load = 0; m_orphan = 1;
            end
        end
    endtask

    task automatic compare();
        bit srch, mreq, wbs, slp, dn;
        srch = m_load && !m_checked;
        mreq = m_load && m_checked && !m_issued && !m_has_res;
        wbs  = m_load && m_has_res;
        slp  = srch && kill_mem_req && !forward && !flush;
        dn   = wbs && wb_ready && !flush;
        chk("m_sel_index",   32'(sel_index),       srch ? 32'(m_idx) : 32'd0);
        chk("m_mem_req_vld", 32'(mem_req_valid),   32'(mreq));
        chk("m_mem_req_adr", mem_req_addr,         mreq ? m_addr : 32'd0);
        chk("m_sleep_vld",   32'(ldq_sleep_valid), 32'(slp));
        chk("m_sleep_idx",   32'(ldq_sleep_index), slp ? 32'(m_idx) : 32'd0);
        chk("m_done_vld",    32'(ldq_done_valid),  32'(dn));
        chk("m_done_idx",    32'(ldq_done_index),  dn ? 32'(m_idx) : 32'd0);
        chk("m_wb_vld",      32'(wb_valid),        32'(wbs));
        chk("m_wb_data",     wb_data,              wbs ? m_res : 32'd0);
        chk("m_wb_tag",      32'(wb_rob_tag),      wbs ? 32'(m_tag) : 32'd0);
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        compare();
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1; flush = 0; ldq_ready = 0; ldq_head = 0;
        kill_mem_req = 0; forward = 0; stq_forward_index = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0; wb_ready = 0;
        for (int i = 0; i < N; i++) begin
            ldq_address[i*XL +: XL] = 32'h1000 * (i + 1);
            ldq_rob_tag[i*TW +: TW] = 5'(i + 10);
        end
        for (int i = 0; i < S; i++) stq_data[i*XL +: XL] = 32'hA000_0000 + i;
        stq_data[3*XL +: XL] = 32'hDEAD_BEEF;

        tick(); tick();
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 0);
        chk("rst_sel_index", 32'(sel_index), 0);
        reset = 0;
        tick();

        // store-to-load forward
        ldq_ready = 8'b0000_0100; kill_mem_req = 1; forward = 1; stq_forward_index = 3;
        tick();
        chk("fwd_sel_index", 32'(sel_index), 2);
        ldq_ready = 0;
        tick();
        chk("fwd_wb_valid", 32'(wb_valid), 1);
        chk("fwd_wb_data", wb_data, 32'hDEAD_BEEF);
        chk("fwd_wb_tag", 32'(wb_rob_tag), 12);
        tick();
        chk("fwd_wb_hold", wb_data, 32'hDEAD_BEEF);
        wb_ready = 1; #1;
        chk("fwd_done_valid", 32'(ldq_done_valid), 1);
        chk("fwd_done_index", 32'(ldq_done_index), 2);
        tick();
        wb_ready = 0; kill_mem_req = 0; forward = 0;
        chk("fwd_retired", 32'(wb_valid), 0);

        // sleep on unforwardable older store
        ldq_ready = 8'b0010_0000; kill_mem_req = 1; forward = 0;
        tick();
        chk("slp_valid", 32'(ldq_sleep_valid), 1);
        chk("slp_index", 32'(ldq_sleep_index), 5);
        ldq_ready = 0;
        tick();
        chk("slp_pulse_width", 32'(ldq_sleep_valid), 0);
        chk("slp_no_req", 32'(mem_req_valid), 0);
        chk("slp_no_wb", 32'(wb_valid), 0);
        kill_mem_req = 0;
        tick();

        // memory path with backpressure
        ldq_ready = 8'b0000_0001;
        tick();
        ldq_ready = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mem_req_valid_hold", 32'(mem_req_valid), 1);
            chk("mem_req_addr_hold", mem_req_addr, 32'h1000);
        end
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        chk("mem_req_dropped", 32'(mem_req_valid), 0);
        tick();
        mem_resp_valid = 1; mem_resp_data = 32'h1234_5678;
        tick();
        mem_resp_valid = 0;
        chk("mem_wb_data", wb_data, 32'h1234_5678);
        chk("mem_wb_tag", 32'(wb_rob_tag), 10);
        wb_ready = 1;
        tick();
        wb_ready = 0;

        // circular age order from head 5
        ldq_head = 5; ldq_ready = 8'b0100_0010; kill_mem_req = 1; forward = 1; stq_forward_index = 0;
        tick();
        chk("wrap_first_sel", 32'(sel_index), 6);
        ldq_ready = 8'b0000_0010;
        tick();
        chk("wrap_first_tag", 32'(wb_rob_tag), 16);
        chk("wrap_first_data", wb_data, 32'hA000_0000);
        wb_ready = 1;
        tick();
        wb_ready = 0;
        tick();
        chk("wrap_second_sel", 32'(sel_index), 1);
        ldq_ready = 0;
        tick();
        chk("wrap_second_tag", 32'(wb_rob_tag), 11);
        wb_ready = 1;
        tick();
        wb_ready = 0; kill_mem_req = 0; forward = 0; ldq_head = 0;

        // flush while waiting for memory drains the stale response
        ldq_ready = 8'b0000_1000;
        tick();
        ldq_ready = 0;
        tick();
        chk("drain_req_addr", mem_req_addr, 32'h4000);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0; flush = 1;
        tick();
        flush = 0; ldq_ready = 8'b0001_0000;
        tick();
        chk("drain_no_req", 32'(mem_req_valid), 0);
        mem_resp_valid = 1; mem_resp_data = 32'hBAD0_BAD0;
        tick();
        mem_resp_valid = 0;
        chk("drain_resp_dropped", 32'(wb_valid), 0);
        tick();
        chk("drain_next_sel", 32'(sel_index), 4);
        ldq_ready = 0;
        tick();
        chk("drain_next_addr", mem_req_addr, 32'h5000);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h4444_4444;
        tick();
        mem_resp_valid = 0;
        chk("drain_next_wb", wb_data, 32'h4444_4444);
        wb_ready = 1;
        tick();
        wb_ready = 0;

        // flush in SEARCH, IDLE and MEM_REQ
        ldq_ready = 8'b0000_0100; kill_mem_req = 1; forward = 0;
        tick();
        flush = 1; #1;
        chk("flush_search_no_sleep", 32'(ldq_sleep_valid), 0);
        tick();
        tick();
        chk("flush_idle_no_select", 32'(sel_index), 0);
        flush = 0;
        tick();
        chk("flush_then_select", 32'(sel_index), 2);
        ldq_ready = 0; kill_mem_req = 0;
        tick();
        chk("flush_req_up", 32'(mem_req_valid), 1);
        flush = 1;
        tick();
        flush = 0;
        chk("flush_req_abandoned", 32'(mem_req_valid), 0);
        tick();

        // asynchronous reset during writeback
        ldq_ready = 8'b0000_0100; kill_mem_req = 1; forward = 1; stq_forward_index = 3;
        tick();
        ldq_ready = 0;
        tick();
        chk("rst_pre_wb_valid", 32'(wb_valid), 1);
        reset = 1; #1;
        chk("rst_async_wb_valid", 32'(wb_valid), 0);
        chk("rst_async_wb_data", wb_data, 0);
        chk("rst_async_wb_tag", 32'(wb_rob_tag), 0);
        tick();
        reset = 0; kill_mem_req = 0; forward = 0;
        mem_resp_valid = 1; mem_resp_data = 32'h7777_7777;
        tick();
        mem_resp_valid = 0;
        chk("rst_late_resp", 32'(wb_valid), 0);
        tick();
        chk("rst_idle_no_req", 32'(mem_req_valid), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
